uart_serdes: RTL and testbench

//  Parametrised UART serialiser/deserialiser for sim and FPGA targets.

---
 rtl/uart_serdes.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_serdes.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_serdes.sv
// UART line engine: 16x-oversampled receiver, configurable transmitter, TX/RX FIFOs
// and an internal loopback path from the TX line into the RX synchroniser.
module uart_serdes #(
  parameter int DIVW    = 16,
  parameter int TXDEPTH = 16,
  parameter int RXDEPTH = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [1:0]      cfg_dbits,
  input  logic [1:0]      cfg_parity,
  input  logic            cfg_stop2,
  input  logic            cfg_loopback,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [7:0]      tx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_perr,
  output logic            rx_ferr,
  output logic            rx_brk,
  output logic            overrun,
  input  logic            clr_overrun,
  output logic            tx_busy,
  output logic            tx_pad,
  input  logic            rx_pad
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2} state_t;

  localparam int TXAW = $clog2(TXDEPTH);
  localparam int RXAW = $clog2(RXDEPTH);

  // The >= compare also ends the count at once when cfg_div shrinks below divcnt.
  logic [DIVW-1:0] divcnt;
  logic            tick;
  assign tick = (divcnt >= cfg_div);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)   divcnt <= '0;
    else if (tick) divcnt <= '0;
    else           divcnt <= divcnt + 1'b1;
  end

  logic [7:0]    tx_mem [TXDEPTH];
  logic [TXAW:0] tx_wptr, tx_rptr;
  logic          tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]    tx_head;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[TXAW] != tx_rptr[TXAW]) &&
                    (tx_wptr[TXAW-1:0] == tx_rptr[TXAW-1:0]);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rptr[TXAW-1:0]];

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr[TXAW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
    end
  end

  state_t     tx_state, tx_state_n;
  logic [3:0] tx_phase, tx_phase_n;
  logic [2:0] tx_bitcnt, tx_bitcnt_n, tx_nbm1, tx_nbm1_n;
  logic [7:0] tx_shift, tx_shift_n, tx_mask;
  logic       tx_pbit, tx_pbit_n, tx_paren, tx_paren_n, tx_stop2, tx_stop2_n;
  logic       tx_line, tx_line_n, tx_bit_end, tx_next, tx_load;

  assign tx_mask    = 8'hFF >> (2'd3 - cfg_dbits);
  assign tx_bit_end = tick && (tx_phase == 4'd15);

  always_comb begin
    tx_state_n  = tx_state;
    tx_phase_n  = tx_phase;
    tx_bitcnt_n = tx_bitcnt;
    tx_shift_n  = tx_shift;
    tx_pbit_n   = tx_pbit;
    tx_nbm1_n   = tx_nbm1;
    tx_paren_n  = tx_paren;
    tx_stop2_n  = tx_stop2;
    tx_next     = 1'b0;
    tx_load     = 1'b0;
    tx_pop      = 1'b0;
    if (tick) tx_phase_n = tx_phase + 1'b1;
    case (tx_state)
      S_IDLE: begin
        tx_phase_n = '0;
        if (tick && !tx_empty) tx_load = 1'b1;
      end
      S_START:  if (tx_bit_end) tx_state_n = S_DATA;
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bitcnt == tx_nbm1) begin
            tx_state_n = tx_paren ? S_PARITY : S_STOP;
          end else begin
            tx_bitcnt_n = tx_bitcnt + 1'b1;
            tx_shift_n  = tx_shift >> 1;
          end
        end
      end
      S_PARITY: if (tx_bit_end) tx_state_n = S_STOP;
      S_STOP: begin
        if (tx_bit_end) begin
          if (tx_stop2) tx_state_n = S_STOP2;
          else          tx_next    = 1'b1;
        end
      end
      S_STOP2:  if (tx_bit_end) tx_next = 1'b1;
      default:  tx_state_n = S_IDLE;
    endcase
    // End of a frame chains straight into the next START when a byte is waiting.
    if (tx_next) begin
      if (tx_empty) tx_state_n = S_IDLE;
      else          tx_load    = 1'b1;
    end
    if (tx_load) begin
      tx_pop      = 1'b1;
      tx_state_n  = S_START;
      tx_phase_n  = '0;
      tx_bitcnt_n = '0;
      tx_shift_n  = tx_head & tx_mask;
      tx_pbit_n   = (^(tx_head & tx_mask)) ^ cfg_parity[1];
      tx_nbm1_n   = {1'b1, cfg_dbits};
      tx_paren_n  = ^cfg_parity;
      tx_stop2_n  = cfg_stop2;
    end
    case (tx_state_n)
      S_START:  tx_line_n = 1'b0;
      S_DATA:   tx_line_n = tx_shift_n[0];
      S_PARITY: tx_line_n = tx_pbit_n;
      default:  tx_line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state  <= S_IDLE;
      tx_phase  <= '0;
      tx_bitcnt <= '0;
      tx_shift  <= '0;
      tx_pbit   <= 1'b0;
      tx_nbm1   <= 3'd7;
      tx_paren  <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_line   <= 1'b1;
      tx_pad    <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_phase  <= tx_phase_n;
      tx_bitcnt <= tx_bitcnt_n;
      tx_shift  <= tx_shift_n;
      tx_pbit   <= tx_pbit_n;
      tx_nbm1   <= tx_nbm1_n;
      tx_paren  <= tx_paren_n;
      tx_stop2  <= tx_stop2_n;
      tx_line   <= tx_line_n;
      tx_pad    <= tx_line_n | cfg_loopback;
    end
  end

  assign tx_busy = !tx_empty || (tx_state != S_IDLE);

  logic rx_s1, rx_s2, rx_bit;
  assign rx_bit = rx_s2;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= cfg_loopback ? tx_line : rx_pad;
      rx_s2 <= rx_s1;
    end
  end

  state_t     rx_state, rx_state_n;
  logic [3:0] rx_phase;
  logic [2:0] rx_bitcnt, rx_nbm1;
  logic [7:0] rx_shift;
  logic       rx_pacc, rx_pbit, rx_paren, rx_podd, rx_armed;
  logic       rx_start, rx_mid, rx_bit_end, rx_take_data, rx_take_par, rx_take_stop;

  assign rx_mid     = tick && (rx_phase == 4'd7);
  assign rx_bit_end = tick && (rx_phase == 4'd15);

  always_comb begin
    rx_state_n   = rx_state;
    rx_start     = 1'b0;
    rx_take_data = 1'b0;
    rx_take_par  = 1'b0;
    rx_take_stop = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_armed && !rx_bit) begin
          rx_start   = 1'b1;
          rx_state_n = S_START;
        end
      end
      S_START:  if (rx_mid) rx_state_n = rx_bit ? S_IDLE : S_DATA;
      S_DATA: begin
        if (rx_bit_end) begin
          rx_take_data = 1'b1;
          if (rx_bitcnt == rx_nbm1) rx_state_n = rx_paren ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_take_par = 1'b1;
          rx_state_n  = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_bit_end) begin
          rx_take_stop = 1'b1;
          rx_state_n   = S_IDLE;
        end
      end
      default:  rx_state_n = S_IDLE;
    endcase
  end

  // A start is only accepted after the line has been seen idle-high, so a held-low
  // line (break) yields one entry rather than a stream of them.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_state  <= S_IDLE;
      rx_phase  <= '0;
      rx_bitcnt <= '0;
      rx_nbm1   <= 3'd7;
      rx_shift  <= '0;
      rx_pacc   <= 1'b0;
      rx_pbit   <= 1'b0;
      rx_paren  <= 1'b0;
      rx_podd   <= 1'b0;
      rx_armed  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_start) begin
        rx_phase  <= '0;
        rx_bitcnt <= '0;
        rx_shift  <= '0;
        rx_pacc   <= 1'b0;
        rx_pbit   <= 1'b0;
        rx_nbm1   <= {1'b1, cfg_dbits};
        rx_paren  <= ^cfg_parity;
        rx_podd   <= cfg_parity[1];
        rx_armed  <= 1'b0;
      end else begin
        if (rx_state == S_START && rx_mid) rx_phase <= '0;
        else if (tick)                     rx_phase <= rx_phase + 1'b1;
        if (rx_state == S_IDLE && rx_s1 && rx_s2) rx_armed <= 1'b1;
        if (rx_take_data) begin
          rx_shift[rx_bitcnt] <= rx_bit;
          rx_pacc             <= rx_pacc ^ rx_bit;
          rx_bitcnt           <= rx_bitcnt + 1'b1;
        end
        if (rx_take_par) rx_pbit <= rx_bit;
      end
    end
  end

  logic [10:0]   rx_mem [RXDEPTH];
  logic [RXAW:0] rx_wptr, rx_rptr;
  logic          rx_empty, rx_full, rx_pop, rx_wr;
  logic [10:0]   rx_entry;
  logic          e_ferr, e_perr, e_brk;

  assign e_ferr   = !rx_bit;
  assign e_perr   = rx_paren && (rx_pacc ^ rx_pbit ^ rx_podd);
  assign e_brk    = e_ferr && (rx_shift == 8'h00) && !rx_pbit;
  assign rx_entry = {e_brk, e_ferr, e_perr, rx_shift};

  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[RXAW] != rx_rptr[RXAW]) &&
                    (rx_wptr[RXAW-1:0] == rx_rptr[RXAW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_wr    = rx_take_stop && (!rx_full || rx_pop);
  assign {rx_brk, rx_ferr, rx_perr, rx_data} = rx_mem[rx_rptr[RXAW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wptr[RXAW-1:0]] <= rx_entry;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_wr)  rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
      if (rx_take_stop && rx_full && !rx_pop) overrun <= 1'b1;
      else if (clr_overrun)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// Directed bench for uart_serdes: frame-level model of the line format plus an RX
// scoreboard checked on every pop, with literal expectations for the fixed scenarios.
module tb_uart_serdes;
  localparam int DIVW    = 16;
  localparam int TXDEPTH = 16;
  localparam int RXDEPTH = 16;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [DIVW-1:0] cfg_div = 16'd3;
  logic [1:0]      cfg_dbits = 2'd3;
  logic [1:0]      cfg_parity = 2'd0;
  logic            cfg_stop2 = 1'b0;
  logic            cfg_loopback = 1'b0;
  logic            tx_valid = 1'b0;
  logic            tx_ready;
  logic [7:0]      tx_data = 8'h00;
  logic            rx_valid;
  logic            rx_ready = 1'b1;
  logic [7:0]      rx_data;
  logic            rx_perr, rx_ferr, rx_brk;
  logic            overrun;
  logic            clr_overrun = 1'b0;
  logic            tx_busy;
  logic            tx_pad;
  logic            rx_pad = 1'b1;

  always #5 clk = ~clk;

  uart_serdes #(.DIVW(DIVW), .TXDEPTH(TXDEPTH), .RXDEPTH(RXDEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .cfg_div(cfg_div), .cfg_dbits(cfg_dbits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .cfg_loopback(cfg_loopback),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_brk(rx_brk),
    .overrun(overrun), .clr_overrun(clr_overrun),
    .tx_busy(tx_busy), .tx_pad(tx_pad), .rx_pad(rx_pad)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Line-level model: the bit sequence a frame occupies on the wire.
  bit frame_q[$];

  function automatic void build_frame(input logic [7:0] b, input int dbits, input int parity,
                                      input bit stop2, input bit bad_par, input bit stop_val);
    int  n;
    bit  p;
    n = dbits + 5;
    p = 1'b0;
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(b[i]);
      p = p ^ b[i];
    end
    if (parity == 1 || parity == 2) frame_q.push_back(p ^ (parity == 2) ^ bad_par);
    frame_q.push_back(stop_val);
    if (stop2) frame_q.push_back(1'b1);
  endfunction

  function automatic logic [10:0] exp_entry(input logic [7:0] b, input int dbits, input int parity,
                                            input bit bad_par, input bit stop_val);
    logic [7:0] d;
    bit         paren, pbit;
    d     = b & 8'((1 << (dbits + 5)) - 1);
    paren = (parity == 1 || parity == 2);
    pbit  = paren ? ((^d) ^ (parity == 2) ^ bad_par) : 1'b0;
    return {(!stop_val && d == 8'h00 && !pbit), !stop_val, paren && bad_par, d};
  endfunction

  // RX scoreboard: every entry the DUT hands over is compared with the model queue.
  logic [10:0] rx_exp[$];
  int          rx_seen = 0;

  always @(negedge clk) begin
    if (nreset && rx_valid && rx_ready) begin
      check("rx_entry_expected", rx_exp.size() > 0, 1);
      if (rx_exp.size() > 0) check("rx_entry", {rx_brk, rx_ferr, rx_perr, rx_data}, rx_exp.pop_front());
      rx_seen++;
    end
  end

  task automatic push_tx(input logic [7:0] b);
    for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input bit bad_par, input bit stop_val);
    int bt;
    bt = 16 * (int'(cfg_div) + 1);
    build_frame(b, int'(cfg_dbits), int'(cfg_parity), 1'b0, bad_par, stop_val);
    foreach (frame_q[i]) begin
      rx_pad = frame_q[i];
      repeat (bt) @(negedge clk);
    end
    rx_pad = 1'b1;
  endtask

  task automatic wait_rx_drained(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rx_exp.size() == 0 && !rx_valid) break;
    end
    check(name, rx_exp.size(), 0);
  endtask

  bit pads [1024];

  initial begin
    int first, end_k, zeros, base;
    bit low_seen;

    repeat (3) @(negedge clk);
    check("reset_tx_pad",   tx_pad,   1);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_overrun",  overrun,  0);
    check("reset_tx_busy",  tx_busy,  0);
    nreset = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0x55 at 64 clk per bit
    push_tx(8'h55);
    first = -1;
    for (int i = 0; i < 200 && first < 0; i++) begin
      if (tx_pad == 1'b0) first = i;
      else @(negedge clk);
    end
    check("t1_start_seen", first >= 0, 1);
    end_k = -1;
    for (int k = 0; k < 800; k++) begin
      pads[k] = tx_pad;
      if (!tx_busy && end_k < 0) end_k = k;
      @(negedge clk);
    end
    zeros = 0;
    while (zeros < 800 && pads[zeros] == 1'b0) zeros++;
    check("t1_start_len", zeros, 64);
    build_frame(8'h55, 3, 0, 1'b0, 1'b0, 1'b1);
    foreach (frame_q[i]) check($sformatf("t1_bit%0d", i), pads[i*64+32], frame_q[i]);
    check("t1_busy_drop", end_k, 640);
    check("t1_idle_after", pads[700], 1);

    // Loopback 7E2: upper bit of 0x41/0x7F dropped, parity even and correct
    cfg_loopback = 1'b1;
    cfg_dbits    = 2'd2;
    cfg_parity   = 2'b01;
    cfg_stop2    = 1'b1;
    rx_exp.push_back(11'h041);
    rx_exp.push_back(11'h07F);
    base = rx_seen;
    push_tx(8'h41);
    push_tx(8'h7F);
    low_seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!tx_pad) low_seen = 1'b1;
      if (rx_exp.size() == 0 && !tx_busy && !rx_valid) break;
    end
    check("t2_drained", rx_exp.size(), 0);
    check("t2_count", rx_seen - base, 2);
    check("t2_pad_held", low_seen, 0);
    cfg_loopback = 1'b0;
    cfg_stop2    = 1'b0;
    repeat (128) @(negedge clk);

    // 8O1 0xA5: bad parity, then good parity with stop bit low
    cfg_dbits  = 2'd3;
    cfg_parity = 2'b10;
    rx_exp.push_back(11'h1A5);
    rx_exp.push_back(11'h2A5);
    drive_rx(8'hA5, 1'b1, 1'b1);
    repeat (128) @(negedge clk);
    drive_rx(8'hA5, 1'b0, 1'b0);
    repeat (128) @(negedge clk);
    wait_rx_drained("t3_drained", 2000);

    // Break: line low for 12 bit times at 8N1
    cfg_parity = 2'b00;
    rx_exp.push_back(11'h600);
    base   = rx_seen;
    rx_pad = 1'b0;
    repeat (12*64) @(negedge clk);
    check("t4_one_entry", rx_seen - base, 1);
    rx_pad = 1'b1;
    repeat (3*64) @(negedge clk);
    check("t4_no_second", rx_seen - base, 1);
    check("t4_queue_empty", rx_exp.size(), 0);

    // Overrun: RXDEPTH+1 frames with the consumer stalled
    rx_ready = 1'b0;
    for (int i = 0; i <= RXDEPTH; i++) begin
      logic [7:0] b;
      b = 8'(i * 37 + 5);
      if (i == RXDEPTH) check("t5_no_overrun_at_full", overrun, 0);
      if (i < RXDEPTH) rx_exp.push_back(exp_entry(b, 3, 0, 1'b0, 1'b1));
      drive_rx(b, 1'b0, 1'b1);
      repeat (64) @(negedge clk);
    end
    check("t5_overrun_set", overrun, 1);
    check("t5_rx_valid", rx_valid, 1);
    base     = rx_seen;
    rx_ready = 1'b1;
    wait_rx_drained("t5_drained", 200);
    check("t5_kept", rx_seen - base, RXDEPTH);
    check("t5_overrun_sticky", overrun, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t5_overrun_clr", overrun, 0);

    // TX FIFO fill with the divider stalled, then reset mid-frame
    cfg_div = 16'hFFFF;
    nreset  = 1'b0;
    @(negedge clk);
    nreset  = 1'b1;
    @(negedge clk);
    for (int i = 0; i < TXDEPTH; i++) begin
      if (i == TXDEPTH - 1) check("t6_ready_before_last", tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = 8'(8'hC0 + i);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("t6_full_ready", tx_ready, 0);
    check("t6_busy", tx_busy, 1);
    check("t6_pad_idle", tx_pad, 1);
    cfg_div = 16'd3;
    first = -1;
    for (int i = 0; i < 100 && first < 0; i++) begin
      @(negedge clk);
      if (!tx_pad) first = i;
    end
    check("t6_frame_started", first >= 0, 1);
    repeat (100) @(negedge clk);
    nreset = 1'b0;
    #1;
    check("t6_rst_pad", tx_pad, 1);
    check("t6_rst_ready", tx_ready, 1);
    check("t6_rst_busy", tx_busy, 0);
    check("t6_rst_rx_valid", rx_valid, 0);
    @(negedge clk);
    nreset = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_pad) low_seen = 1'b1;
    end
    check("t6_no_resume", low_seen, 0);
    check("t6_idle_busy", tx_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
